// File: rtl/irq_pkg.sv
// Shared types for the multi-source interrupt controller.
// Mode encoding matches the CSR field layout of irq_mode_i.
package irq_pkg;

  typedef enum logic [1:0] {
    LEVEL_P  = 2'd0,
    STROBE_N = 2'd1,
    LEVEL_N  = 2'd2,
    STROBE_P = 2'd3
  } irq_mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    HOLDOFF = 2'd2
  } strobe_state_t;

  function automatic logic is_active_low(
    input irq_mode_t m
  );
    return (m == STROBE_N) || (m == LEVEL_N);
  endfunction

  function automatic logic is_strobe(
    input irq_mode_t m
  );
    return (m == STROBE_N) || (m == STROBE_P);
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Source/CSR side bundle of the interrupt controller.
// master = peripheral/CSR side, slave = controller.
interface irq_ctrl_if #(
  parameter int unsigned N_SRC = 32,
  parameter int unsigned ID_W  = 5
);

  logic [N_SRC-1:0] status_i;
  logic [N_SRC-1:0] mask_i;
  logic [N_SRC-1:0] clear_i;
  logic [N_SRC-1:0] pending_o;
  logic [ID_W-1:0]  irq_id_o;
  logic             irq_id_vld_o;
  logic             irq_o;

  modport master (
    output status_i,
    output mask_i,
    output clear_i,
    input  pending_o,
    input  irq_id_o,
    input  irq_id_vld_o,
    input  irq_o
  );

  modport slave (
    input  status_i,
    input  mask_i,
    input  clear_i,
    output pending_o,
    output irq_id_o,
    output irq_id_vld_o,
    output irq_o
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder, purely combinational.
// id_o is 0 when no request is set; vld_o flags any request.
module irq_prio_enc #(
  parameter int unsigned N_SRC = 32,
  parameter int unsigned ID_W  = 5
) (
  input  logic [N_SRC-1:0] req_i,
  output logic [ID_W-1:0]  id_o,
  output logic             vld_o
);

  always_comb begin
    id_o = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o = ID_W'(i);
      end
    end
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller: sticky pending, mask, level/strobe IRQ.
// Define IRQ_HOLDOFF_EN to enforce a minimum gap between strobes.
module irq_ctrl #(
  parameter int unsigned N_SRC      = 32,
  parameter int unsigned LEN_W      = 16,
  parameter logic        INIT_VALUE = 1'b0,
  parameter int unsigned ID_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [1:0]       irq_mode_i,
  input  logic [LEN_W-1:0] length_i,
  input  logic [LEN_W-1:0] holdoff_i,
  irq_ctrl_if.slave        bus
);

  import irq_pkg::*;

  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] pend_d;
  logic [N_SRC-1:0] hit;
  logic [ID_W-1:0]  id_d;
  logic [ID_W-1:0]  id_q;
  logic             vld_d;
  logic             vld_q;
  logic             act;
  logic             evt;

  irq_mode_t        mode;
  irq_mode_t        mode_q;
  logic             mode_vld_q;
  logic             mode_chg;
  logic             low;
  logic             strb_mode;

  strobe_state_t    st_q;
  strobe_state_t    st_d;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;
  logic [LEN_W-1:0] len_ld;
  logic             flag_q;
  logic             flag_d;
  logic             irq_q;
  logic             irq_d;

  assign mode      = irq_mode_t'(irq_mode_i);
  assign low       = is_active_low(mode);
  assign strb_mode = is_strobe(mode);
  assign mode_chg  = mode_vld_q && (mode != mode_q);

  // Set beats a same-cycle clear so an event is never lost.
  assign pend_d = bus.status_i | (pend_q & ~bus.clear_i);
  assign hit    = pend_d & bus.mask_i;
  assign act    = |hit;
  assign evt    = |(bus.status_i & bus.mask_i);

  assign len_ld = (length_i == '0) ? '0
                : length_i - LEN_W'(1);

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_enc (
    .req_i (hit),
    .id_o  (id_d),
    .vld_o (vld_d)
  );

`ifndef IRQ_HOLDOFF_EN
  logic unused_holdoff;
  assign unused_holdoff = ^holdoff_i;
`endif

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (mode_chg || !strb_mode) begin
      st_d   = IDLE;
      cnt_d  = '0;
      flag_d = 1'b0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (evt) begin
            st_d  = STROBE;
            cnt_d = len_ld;
          end
        end
        STROBE: begin
          if (evt) begin
            cnt_d = len_ld;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LEN_W'(1);
          end else begin
`ifdef IRQ_HOLDOFF_EN
            // Exit edge is the first inactive cycle.
            if (holdoff_i != '0) begin
              st_d   = HOLDOFF;
              cnt_d  = holdoff_i - LEN_W'(1);
              flag_d = 1'b0;
            end else begin
              st_d = IDLE;
            end
`else
            st_d = IDLE;
`endif
          end
        end
        HOLDOFF: begin
          if (cnt_q != '0) begin
            cnt_d  = cnt_q - LEN_W'(1);
            flag_d = flag_q | evt;
          end else if (flag_q | evt) begin
            st_d   = STROBE;
            cnt_d  = len_ld;
            flag_d = 1'b0;
          end else begin
            st_d = IDLE;
          end
        end
        default: begin
          st_d   = IDLE;
          cnt_d  = '0;
          flag_d = 1'b0;
        end
      endcase
    end
  end

  assign irq_d = strb_mode ? ((st_d == STROBE) ^ low)
               : (act ^ low);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      pend_q     <= '0;
      id_q       <= '0;
      vld_q      <= 1'b0;
      st_q       <= IDLE;
      cnt_q      <= '0;
      flag_q     <= 1'b0;
      irq_q      <= INIT_VALUE;
      mode_q     <= LEVEL_P;
      mode_vld_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      id_q       <= id_d;
      vld_q      <= vld_d;
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      flag_q     <= flag_d;
      irq_q      <= irq_d;
      mode_q     <= mode;
      mode_vld_q <= 1'b1;
    end
  end

  assign bus.pending_o    = pend_q;
  assign bus.irq_id_o     = id_q;
  assign bus.irq_id_vld_o = vld_q;
  assign bus.irq_o        = irq_q;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Multi-source interrupt controller. Successor to the single-output IRQ generator.
- Latches N_SRC pulse sources into sticky per-source pending bits with per-source mask and write-1-to-clear.
- Drives one IRQ line in level or strobe mode, either polarity, plus the encoded ID of the highest-priority active source.
- Sits between peripheral status pulses and the CSR block / CPU interrupt input.

Parameters:
N_SRC, 32, number of interrupt sources (1..64)
LEN_W, 16, width of strobe length and holdoff counters
INIT_VALUE, 1'b0, irq_o value while in reset, before the mode is applied
ID_W, $clog2(N_SRC) (min 1), width of irq_id_o

Ports:
clk_i  in  1  clock
arst_n_i  in  1  asynchronous active-low reset
irq_mode_i  in  2  0 LEVEL_P, 1 STROBE_N, 2 LEVEL_N, 3 STROBE_P; quasi-static
length_i  in  LEN_W  strobe width in cycles; 0 treated as 1
holdoff_i  in  LEN_W  minimum inactive cycles between strobes (used only with IRQ_HOLDOFF_EN)
status_i  in  N_SRC  per-source event pulses
mask_i  in  N_SRC  1 = source enabled
clear_i  in  N_SRC  W1C strobe vector from CSR
pending_o  out  N_SRC  raw sticky pending bits (unmasked)
irq_id_o  out  ID_W  lowest index of (pending & mask); 0 when none
irq_id_vld_o  out  1  |(pending & mask)
irq_o  out  1  generated interrupt

Behaviour:
- Reset (async assert, sync deassert handled upstream): pending = 0, irq_id_o = 0, irq_id_vld_o = 0, counters = 0, FSM = IDLE, irq_o = INIT_VALUE.
- Pending update per bit k: next = status_i[k] | (pending[k] & ~clear_i[k]). Set wins over a same-cycle clear, so no event is lost.
- Pending is set regardless of the mask. Masking gates only irq/ID.
- All outputs are registered. A status pulse at cycle t is visible on pending_o, irq_id_o and irq_o at t+1.
- act = |(pending & mask_i) using next-state pending; evt = |(status_i & mask_i).
- LEVEL_P / LEVEL_N: irq_o = act (LEVEL_P) or ~act (LEVEL_N). Deasserts the cycle after the last active bit is cleared or masked. Unmasking an already-pending bit asserts next cycle.
- STROBE_P / STROBE_N:
  - Triggered by evt only; pending alone does not retrigger.
  - FSM IDLE -> STROBE on evt; counter loads max(length_i,1)-1; irq_o active.
  - In STROBE: evt reloads the counter (extends the pulse). Counter decrements; at 0 with no evt -> IDLE, irq_o inactive next cycle.
  - Pulse width for an isolated event = max(length_i,1) cycles exactly.
- Active level: P modes active 1, N modes active 0. Inactive level is the complement.
- A change of irq_mode_i forces FSM to IDLE and irq_o to the new mode's inactive level next cycle (LEVEL modes: recomputed from act). Pending is unaffected.
- length_i is sampled only at load/reload.

Optional Feature:
IRQ_HOLDOFF_EN
- Defined:
  - STROBE exit goes to HOLDOFF (counter loads holdoff_i), irq_o inactive.
  - Events during HOLDOFF set a flag and do not strobe.
  - At counter 0: flag set -> STROBE (one merged strobe), else -> IDLE.
  - holdoff_i = 0 behaves as undefined macro.
  - Level modes are unaffected.
- Not defined: no HOLDOFF state; holdoff_i is ignored.

Decomposition:
- Package irq_pkg:
  - irq_mode_t enum (LEVEL_P=0, STROBE_N=1, LEVEL_N=2, STROBE_P=3)
  - strobe_state_t enum (IDLE, STROBE, HOLDOFF)
  - function is_active_low(irq_mode_t)
- Sub-module irq_prio_enc: parametrised N_SRC-to-ID_W lowest-index priority encoder with valid output, combinational, registered in the parent.

Test Plan:
- Reset then LEVEL_P, mask=0x1, status pulse bit0 at t -> pending_o=0x1, irq_o=1, irq_id_o=0, vld=1 at t+1; clear_i=0x1 -> irq_o=0 next cycle.
- Same-cycle status_i[3] and clear_i[3] with pending[3]=1 -> pending[3] stays 1; mask=0x8 and status 0x28 -> irq_id_o=3.
- STROBE_N, length_i=4, single pulse -> irq_o low exactly 4 cycles from t+1, then high; length_i=0 -> 1 cycle.
- STROBE_P, length_i=5, second event 3 cycles into strobe -> pulse extended to 3+5=8 cycles total.
- Mask=0, status pulse bit2 -> pending_o[2]=1, irq_o inactive; set mask[2] in LEVEL_P -> irq_o=1 next cycle; in STROBE_P -> no strobe.
- IRQ_HOLDOFF_EN, STROBE_P, length=2, holdoff=10, three events during holdoff -> exactly one 2-cycle strobe after holdoff expires. Async reset mid-strobe -> irq_o=INIT_VALUE immediately.
